// File: rtl/ghost_mover.sv
// Ghost tile-position holder: probes the four maze neighbours,
// publishes passability flags and steps the ghost one tile.
module ghost_mover #(
    parameter int GRID_W     = 28,
    parameter int GRID_H     = 31,
    parameter int X_BITS     = 5,
    parameter int Y_BITS     = 5,
    parameter int ADDR_BITS  = 10,
    parameter int TUNNEL_ROW = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 update,
    input  logic [X_BITS-1:0]    intPosX,
    input  logic [Y_BITS-1:0]    intPosY,
    input  logic                 doorPass,
    input  logic [1:0]           mazeRdData,
    input  logic [1:0]           dirToMove,
    output logic [ADDR_BITS-1:0] mazeAddr,
    output logic                 canMoveU,
    output logic                 canMoveR,
    output logic                 canMoveD,
    output logic                 canMoveL,
    output logic                 flagsValid,
    output logic [X_BITS-1:0]    ghostPosX,
    output logic [Y_BITS-1:0]    ghostPosY,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE,
        PROBE_U,
        PROBE_R,
        PROBE_D,
        PROBE_L,
        CAPTURE_L,
        DECIDE,
        MOVE
    } state_t;

    localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(GRID_H - 1);
    localparam logic [Y_BITS-1:0] Y_TUN = Y_BITS'(TUNNEL_ROW);

    state_t                 state_q;
    logic [X_BITS-1:0]      pos_x_q;
    logic [Y_BITS-1:0]      pos_y_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   can_u_q, can_r_q, can_d_q, can_l_q;
    logic                   valid_q, busy_q, done_q;

    logic                   ok_u, ok_r, ok_d, ok_l, tunnel, pass;
    logic [X_BITS-1:0]      x_r, x_l;
    logic [Y_BITS-1:0]      y_u, y_d;

    function automatic logic [ADDR_BITS-1:0] tile_addr(
        input logic [X_BITS-1:0] x,
        input logic [Y_BITS-1:0] y
    );
        return ADDR_BITS'(y) * ADDR_BITS'(GRID_W) + ADDR_BITS'(x);
    endfunction

    // Position is frozen for the whole step, so neighbours are pure decode.
    assign tunnel = (pos_y_q == Y_TUN);
    assign ok_u   = (pos_y_q != '0);
    assign ok_d   = (pos_y_q != Y_MAX);
    assign ok_r   = (pos_x_q != X_MAX) || tunnel;
    assign ok_l   = (pos_x_q != '0) || tunnel;
    assign x_r    = (pos_x_q == X_MAX) ? '0 : pos_x_q + 1'b1;
    assign x_l    = (pos_x_q == '0) ? X_MAX : pos_x_q - 1'b1;
    assign y_u    = pos_y_q - 1'b1;
    assign y_d    = pos_y_q + 1'b1;
    assign pass   = (mazeRdData != 2'b01) &&
                    ((mazeRdData != 2'b10) || doorPass);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pos_x_q <= intPosX;
            pos_y_q <= intPosY;
            addr_q  <= '0;
            can_u_q <= 1'b0;
            can_r_q <= 1'b0;
            can_d_q <= 1'b0;
            can_l_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (update) begin
                        state_q <= PROBE_U;
                        busy_q  <= 1'b1;
                        if (ok_u) addr_q <= tile_addr(pos_x_q, y_u);
                    end
                end
                PROBE_U: begin
                    state_q <= PROBE_R;
                    if (ok_r) addr_q <= tile_addr(x_r, pos_y_q);
                end
                PROBE_R: begin
                    state_q <= PROBE_D;
                    can_u_q <= ok_u && pass;
                    if (ok_d) addr_q <= tile_addr(pos_x_q, y_d);
                end
                PROBE_D: begin
                    state_q <= PROBE_L;
                    can_r_q <= ok_r && pass;
                    if (ok_l) addr_q <= tile_addr(x_l, pos_y_q);
                end
                PROBE_L: begin
                    state_q <= CAPTURE_L;
                    can_d_q <= ok_d && pass;
                end
                CAPTURE_L: begin
                    state_q <= DECIDE;
                    can_l_q <= ok_l && pass;
                    valid_q <= 1'b1;
                end
                // Direction is consumed here so the new tile shows in MOVE.
                DECIDE: begin
                    state_q <= MOVE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b1;
                    unique case (dirToMove)
                        2'b00: if (can_u_q) pos_y_q <= y_u;
                        2'b01: if (can_r_q) pos_x_q <= x_r;
                        2'b10: if (can_d_q) pos_y_q <= y_d;
                        2'b11: if (can_l_q) pos_x_q <= x_l;
                    endcase
                end
                MOVE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mazeAddr   = addr_q;
    assign canMoveU   = can_u_q;
    assign canMoveR   = can_r_q;
    assign canMoveD   = can_d_q;
    assign canMoveL   = can_l_q;
    assign flagsValid = valid_q;
    assign ghostPosX  = pos_x_q;
    assign ghostPosY  = pos_y_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
